divider_unit: RTL and testbench
===============================

DIVIDER_UNIT -- requirements
Module: divider_unit

Interface
REQ-001 The block SHALL have a single clock, clk (input, 1): all state updates on its rising edge.
REQ-002 The block SHALL have a reset, rst (input, 1): synchronous and active-high.
REQ-003 The block SHALL have an input enable (1): the EX stage holds a divide-class instruction.
REQ-004 The block SHALL have an input command (DivCommand, 2): DIV, DIVU, REM or REMU.
REQ-005 The block SHALL have inputs srcA and srcB (32 each): dividend and divisor, held stable by the pipeline while stallReq=1.
REQ-006 The block SHALL have an input flush (1): the pipeline controller flush; it aborts the operation.
REQ-007 The block SHALL have an input stall (1): the controller exStall; it freezes a completed result.
REQ-008 The block SHALL have an output stallReq (1): the EX stall request to the pipeline controller.
REQ-009 The block SHALL have an output done (1): the result is valid this cycle.
REQ-010 The block SHALL have an output result (32): the quotient or remainder per command.

Function
REQ-011 The block SHALL implement a state machine with states IDLE, RUN and DONE, plus a 5-bit iteration counter.
REQ-012 In IDLE with enable=1 and flush=0, a special case (divisor==0, or signed srcA==0x80000000 with srcB==0xFFFFFFFF) SHALL transition to DONE; otherwise it SHALL transition to RUN with counter=31.
REQ-013 On entry to RUN, the block SHALL latch operand magnitudes and the result signs (quotient sign = sign(A) xor sign(B); remainder sign = sign(A); signed commands only).
REQ-014 RUN SHALL perform one radix-2 restoring step per cycle, decrement the counter, and transition to DONE after the counter==0 step (32 steps).
REQ-015 In DONE, the block SHALL drive done=1 and present result, with the sign fix-up applied.
REQ-016 In DONE, the block SHALL remain in DONE while stall=1, otherwise transition to IDLE.
REQ-017 The block SHALL compute stallReq = enable & ~flush & (state != DONE), combinationally; stallReq SHALL never be asserted in DONE.
REQ-018 Normal latency SHALL be: enable first seen in cycle 0; stallReq high cycles 0..32; done=1 in cycle 33. Special-case latency: stallReq high in cycle 0 only, done=1 in cycle 1.
REQ-019 For divide-by-zero, the block SHALL return quotient 0xFFFFFFFF (DIV and DIVU) and remainder = srcA (REM and REMU).
REQ-020 For signed overflow, the block SHALL return quotient 0x80000000 and remainder 0.
REQ-021 For flush=1 in any state, the next state SHALL be IDLE, the counter SHALL be cleared, and the partial result SHALL be discarded.
REQ-022 For flush=1 together with enable=1 in IDLE, the block SHALL NOT start an operation.
REQ-023 Outside DONE, done SHALL be 0 and result SHALL be 0.
REQ-024 A change of enable to 0 during RUN without flush SHALL be treated as a flush.

Reset
REQ-025 rst=1 SHALL force, at the next edge, state=IDLE, counter=0, internal remainder/quotient registers=0, done=0, result=0, and stallReq=0; this holds regardless of the current state.
REQ-026 rst SHALL take priority over flush, stall and enable.

Structure
REQ-027 DivCommand (enum) and DIV_ITERATIONS=32 SHALL be placed in ProcessorTypes; the state enum SHALL stay local to the module.
REQ-028 The design SHALL be a single module; no sub-module is warranted, since the datapath is one subtract/shift stage.

Verification
REQ-029 The bench SHALL cover DIVU 100/7: stallReq high for exactly 33 cycles, done in cycle 33, result=14; REMU gives 2.
REQ-030 The bench SHALL cover DIV 0xFFFFFFF9/2: result=0xFFFFFFFD; REM with the same operands gives 0xFFFFFFFF.
REQ-031 The bench SHALL cover DIVU 5/0: result=0xFFFFFFFF; REMU 5/0 gives 5; stallReq high exactly 1 cycle.
REQ-032 The bench SHALL cover DIV 0x80000000/0xFFFFFFFF: result=0x80000000, latency 1; REM gives 0.
REQ-033 The bench SHALL cover flush in RUN cycle 10: stallReq low the same cycle, IDLE next cycle; a new DIVU 9/3 then takes the full 33 cycles and gives result=3.
REQ-034 The bench SHALL cover stall=1 for 3 cycles in DONE, with result and done stable throughout; and rst mid-RUN, which returns the block to IDLE with all outputs 0.

Source files
------------

// File: rtl/ProcessorTypes.sv
// Processor-wide shared types and constants.
package ProcessorTypes;

  // bit 1 selects remainder, bit 0 selects unsigned
  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } DivCommand;

  localparam int unsigned DIV_ITERATIONS = 32;

endpackage

// File: rtl/divider_unit.sv
// Iterative radix-2 restoring divider for the EX stage: 32-step normal path,
// single-cycle special cases (divide by zero, signed overflow).
module divider_unit
  import ProcessorTypes::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  DivCommand   command,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic        flush,
  input  logic        stall,
  output logic        stallReq,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;   // dividend bits shift out the top, quotient bits in the bottom
  logic [31:0] div_q, div_d;   // divisor magnitude
  logic        rem_sel_q, rem_sel_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;

  logic        is_signed, is_rem, a_neg, b_neg, div_by_zero, overflow;
  logic [31:0] a_mag, b_mag;
  logic [32:0] shifted;
  logic [31:0] sub;
  logic        ge;
  logic [31:0] fixed;

  // Operand decode and one restoring step
  always_comb begin
    is_signed   = ~command[0];
    is_rem      = command[1];
    a_neg       = is_signed & srcA[31];
    b_neg       = is_signed & srcB[31];
    a_mag       = a_neg ? (~srcA + 32'd1) : srcA;
    b_mag       = b_neg ? (~srcB + 32'd1) : srcB;
    div_by_zero = (srcB == 32'd0);
    overflow    = is_signed & (srcA == 32'h8000_0000) & (srcB == 32'hFFFF_FFFF);
    shifted     = {rem_q, quo_q[31]};
    ge          = (shifted >= {1'b0, div_q});
    // When ge holds the true difference is below 2^32, so the low bits are exact
    sub         = shifted[31:0] - div_q;
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    rem_sel_d = rem_sel_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;

    unique case (state_q)
      StIdle: begin
        if (enable && !flush) begin
          rem_sel_d = is_rem;
          if (div_by_zero || overflow) begin
            // Results stored directly with no sign fix-up
            state_d = StDone;
            cnt_d   = '0;
            div_d   = '0;
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
            quo_d   = div_by_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
            rem_d   = div_by_zero ? srcA : 32'd0;
          end else begin
            state_d = StRun;
            cnt_d   = 5'(DIV_ITERATIONS - 1);
            quo_d   = a_mag;
            rem_d   = '0;
            div_d   = b_mag;
            q_neg_d = a_neg ^ b_neg;
            r_neg_d = a_neg;
          end
        end
      end
      StRun: begin
        rem_d = ge ? sub : shifted[31:0];
        quo_d = {quo_q[30:0], ge};
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (!stall) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Losing enable mid-run means the instruction left EX: abort like a flush
    if (flush || (state_q == StRun && !enable)) begin
      state_d   = StIdle;
      cnt_d     = '0;
      rem_d     = '0;
      quo_d     = '0;
      div_d     = '0;
      rem_sel_d = 1'b0;
      q_neg_d   = 1'b0;
      r_neg_d   = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      rem_sel_q <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      rem_sel_q <= rem_sel_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
    end
  end

  // Outputs: stall request, done flag and sign-corrected result
  always_comb begin
    stallReq = enable & ~flush & (state_q != StDone);
    done     = (state_q == StDone);
    if (rem_sel_q) begin
      fixed = r_neg_q ? (~rem_q + 32'd1) : rem_q;
    end else begin
      fixed = q_neg_q ? (~quo_q + 32'd1) : quo_q;
    end
    result = done ? fixed : 32'd0;
  end

endmodule

// File: tb/tb_divider_unit.sv
// Self-checking bench for divider_unit: directed table, hand sequences for
// flush/stall/reset, and randomized operations against an arithmetic model.
module tb_divider_unit;
  import ProcessorTypes::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  DivCommand   command = DIVU;
  logic [31:0] srcA = '0;
  logic [31:0] srcB = '0;
  logic        flush = 1'b0;
  logic        stall = 1'b0;
  logic        stallReq;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  divider_unit dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .command  (command),
    .srcA     (srcA),
    .srcB     (srcB),
    .flush    (flush),
    .stall    (stall),
    .stallReq (stallReq),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Architectural reference: RISC-V M-extension divide semantics
  function automatic logic [31:0] ref_result(input DivCommand c, input logic [31:0] a,
                                             input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return (c == DIV || c == DIVU) ? 32'hFFFF_FFFF : a;
    if ((c == DIV || c == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return (c == DIV) ? 32'h8000_0000 : 32'd0;
    case (c)
      DIVU:    return a / b;
      REMU:    return a % b;
      DIV:     return 32'(sa / sb);
      default: return 32'(sa % sb);
    endcase
  endfunction

  function automatic int ref_latency(input DivCommand c, input logic [31:0] a,
                                     input logic [31:0] b);
    if (b == 32'd0) return 1;
    if ((c == DIV || c == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Called just after a rising edge; returns just after a rising edge with enable low.
  task automatic run_op(input DivCommand c, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int sreq);
    command = c;
    srcA    = a;
    srcB    = b;
    enable  = 1'b1;
    lat     = -1;
    sreq    = 0;
    res     = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (stallReq) sreq++;
      if (done) begin
        lat = cyc;
        res = result;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    enable = 1'b0;
  endtask

  typedef struct {
    DivCommand   cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          exp_lat;
    int          exp_sreq;
  } vec_t;

  initial begin
    vec_t        vecs[8];
    logic [31:0] res, held;
    int          lat, sreq;

    vecs[0] = '{DIVU, 32'd100,         32'd7,          32'd14,         33, 33};
    vecs[1] = '{REMU, 32'd100,         32'd7,          32'd2,          33, 33};
    vecs[2] = '{DIV,  32'hFFFF_FFF9,   32'd2,          32'hFFFF_FFFD,  33, 33};
    vecs[3] = '{REM,  32'hFFFF_FFF9,   32'd2,          32'hFFFF_FFFF,  33, 33};
    vecs[4] = '{DIVU, 32'd5,           32'd0,          32'hFFFF_FFFF,  1,  1};
    vecs[5] = '{REMU, 32'd5,           32'd0,          32'd5,          1,  1};
    vecs[6] = '{DIV,  32'h8000_0000,   32'hFFFF_FFFF,  32'h8000_0000,  1,  1};
    vecs[7] = '{REM,  32'h8000_0000,   32'hFFFF_FFFF,  32'd0,          1,  1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_stallreq", {31'd0, stallReq}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed table
    foreach (vecs[i]) begin
      run_op(vecs[i].cmd, vecs[i].a, vecs[i].b, res, lat, sreq);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_stallreq_cycles", i), 32'(sreq), 32'(vecs[i].exp_sreq));
    end

    // Flush in RUN cycle 10
    command = DIVU;
    srcA    = 32'd1000;
    srcB    = 32'd3;
    enable  = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_stallreq_same_cycle", {31'd0, stallReq}, 32'd0);
    check("flush_done_same_cycle", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    flush  = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    check("flush_next_done", {31'd0, done}, 32'd0);
    check("flush_next_result", result, 32'd0);
    @(posedge clk);
    #1;
    run_op(DIVU, 32'd9, 32'd3, res, lat, sreq);
    check("post_flush_result", res, 32'd3);
    check("post_flush_latency", 32'(lat), 32'd33);
    check("post_flush_stallreq_cycles", 32'(sreq), 32'd33);

    // Stall held for 3 cycles in DONE
    command = DIVU;
    srcA    = 32'd100;
    srcB    = 32'd7;
    enable  = 1'b1;
    lat     = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("stall_seq_latency", 32'(lat), 32'd33);
    held  = result;
    check("stall_seq_result", held, 32'd14);
    stall = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("stall_done_c%0d", k), {31'd0, done}, 32'd1);
      check($sformatf("stall_result_c%0d", k), result, 32'd14);
      check($sformatf("stall_stallreq_c%0d", k), {31'd0, stallReq}, 32'd0);
    end
    stall  = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    check("after_stall_done", {31'd0, done}, 32'd0);
    check("after_stall_result", result, 32'd0);
    @(posedge clk);
    #1;

    // Enable dropped mid-run acts as a flush
    command = DIVU;
    srcA    = 32'd1000;
    srcB    = 32'd3;
    enable  = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    enable = 1'b0;
    @(posedge clk);
    #1;
    run_op(DIVU, 32'd9, 32'd3, res, lat, sreq);
    check("enable_drop_result", res, 32'd3);
    check("enable_drop_latency", 32'(lat), 32'd33);

    // Reset mid-RUN
    command = DIVU;
    srcA    = 32'd100;
    srcB    = 32'd7;
    enable  = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    rst    = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("midrun_reset_done", {31'd0, done}, 32'd0);
    check("midrun_reset_result", result, 32'd0);
    check("midrun_reset_stallreq", {31'd0, stallReq}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_op(DIVU, 32'd9, 32'd3, res, lat, sreq);
    check("post_reset_result", res, 32'd3);
    check("post_reset_latency", 32'(lat), 32'd33);

    // Randomized operations against the arithmetic model
    for (int n = 0; n < 40; n++) begin
      DivCommand   c;
      logic [31:0] a, b;
      int          mode;
      c    = DivCommand'($urandom_range(0, 3));
      a    = $urandom;
      b    = $urandom;
      mode = $urandom_range(0, 9);
      if (mode == 0) begin
        b = 32'd0;
      end else if (mode == 1) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end else if (mode == 2) begin
        b = 32'($urandom_range(1, 15));
      end else if (mode == 3) begin
        b = -32'($urandom_range(1, 15));
      end
      run_op(c, a, b, res, lat, sreq);
      check($sformatf("rand%0d_result cmd=%0d a=%08h b=%08h", n, c, a, b), res,
            ref_result(c, a, b));
      check($sformatf("rand%0d_latency", n), 32'(lat), 32'(ref_latency(c, a, b)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
